// File: rtl/oram_hw_pkg.sv
// Shared state encoding and constants for the tree-ORAM path controller.
// Imported by the LFSR and the controller top.
package oram_hw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FETCH,
        PUT,
        EVICT
    } oram_state_e;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int              DEF_BLOCK_BITS = 32;
    localparam int              DEF_N_BLOCKS   = 8;
    localparam int              DEF_K          = 3;
    localparam int              DEF_EVICTS     = 1;
    localparam logic [LFSR_W-1:0] DEF_SEED     = 16'hACE1;

endpackage

// File: rtl/oram_lfsr.sv
// Free-running right-shift Galois LFSR; exposes only the low bits
// the controller consumes as a random leaf.
module oram_lfsr
    import oram_hw_pkg::*;
#(
    parameter int               WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
    parameter int               OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] o_bits
);

    logic [WIDTH-1:0] r_lfsr;

    // One Galois step per cycle; taps fold in when the LSB shifts out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    assign o_bits = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/oram_path_controller.sv
// Tree-ORAM controller: bucket tree and position map in flops, one access at a time.
// Define ORAM_STATS_EN to add the access_cnt / ovf_cnt statistics outputs.
module oram_path_controller
    import oram_hw_pkg::*;
#(
    parameter int          BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int          N_BLOCKS   = DEF_N_BLOCKS,
    parameter int          K          = DEF_K,
    parameter int          EVICTS     = DEF_EVICTS,
    parameter logic [15:0] LFSR_SEED  = DEF_SEED,
    localparam int         L          = $clog2(N_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [L-1:0]          req_block,
    input  logic [BLOCK_BITS-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [BLOCK_BITS-1:0] rsp_rdata,
`ifdef ORAM_STATS_EN
    output logic [31:0]           access_cnt,
    output logic [15:0]           ovf_cnt,
`endif
    output logic                  ovf
);

    localparam int LL    = L - 1;
    localparam int NODES = (1 << L) - 1;
    localparam int LW    = (L > 1) ? $clog2(L) : 1;
    localparam int PW    = (EVICTS > 1) ? $clog2(EVICTS) : 1;
    localparam int SW    = (K > 1) ? $clog2(K) : 1;

    typedef struct packed {
        logic                  valid;
        logic [LL-1:0]         leaf;
        logic [L-1:0]          bnum;
        logic [BLOCK_BITS-1:0] data;
    } tuple_t;

    // Lowest set bit of a slot mask as {found, index}; serves both
    // lowest-free and lowest-match selection.
    function automatic logic [SW:0] lowest(input logic [K-1:0] m);
        lowest = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (m[i]) lowest = {1'b1, SW'(i)};
        end
    endfunction

    oram_state_e           r_state;
    tuple_t                r_tree [1:NODES][K];
    tuple_t                w_tree [1:NODES][K];
    logic [N_BLOCKS-1:0]   r_pv;
    logic [LL-1:0]         r_pos [N_BLOCKS];
    logic [L-1:0]          r_block;
    logic                  r_write;
    logic [BLOCK_BITS-1:0] r_wdata;
    logic [LL-1:0]         r_leaf;
    logic [LL-1:0]         r_p;
    logic [L-1:0]          r_node;
    logic [LW-1:0]         r_lvl;
    logic [PW-1:0]         r_pass;
    logic [BLOCK_BITS-1:0] r_fetched;
    logic                  r_rsp_valid;
    logic [BLOCK_BITS-1:0] r_rsp_rdata;
    logic                  r_ovf;

    logic [LL-1:0]         w_rnd;
    logic [LL-1:0]         w_p;
    logic [LL-1:0]         w_psh;
    logic                  w_pbit;
    logic [L-1:0]          w_child;
    logic [K-1:0]          w_mmask;
    logic [K-1:0]          w_rfree;
    logic [K-1:0]          w_free;
    logic [SW:0]           w_hit;
    logic [SW:0]           w_rslot;
    logic [SW:0]           w_slot;
    logic [LL-1:0]         w_lsh;
    logic [BLOCK_BITS-1:0] w_hit_data;

    oram_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS),
        .OUT_W (LL)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_bits (w_rnd)
    );

    // The eviction leaf is sampled fresh on the first level of each pass.
    assign w_p     = (r_lvl == '0) ? w_rnd : r_p;
    assign w_psh   = ((r_state == EVICT) ? w_p : r_leaf) >> r_lvl;
    assign w_pbit  = w_psh[0];
    assign w_child = {r_node[L-2:0], w_pbit};

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign ovf       = r_ovf;

    // Next tree contents: fetch removal, root insert or one eviction level.
    always_comb begin
        w_tree  = r_tree;
        w_mmask = '0;
        w_rfree = '0;
        w_free  = '0;
        w_slot  = '0;
        w_lsh   = '0;
        for (int s = 0; s < K; s++) begin
            w_mmask[s] = r_tree[r_node][s].valid &&
                         (r_tree[r_node][s].bnum == r_block);
            w_rfree[s] = !r_tree[1][s].valid;
            w_free[s]  = !r_tree[w_child][s].valid;
        end
        w_hit      = lowest(w_mmask);
        w_rslot    = lowest(w_rfree);
        w_hit_data = r_tree[r_node][w_hit[SW-1:0]].data;
        unique case (r_state)
            FETCH: begin
                if (w_hit[SW]) begin
                    w_tree[r_node][w_hit[SW-1:0]].valid = 1'b0;
                end
            end
            PUT: begin
                if (w_rslot[SW]) begin
                    w_tree[1][w_rslot[SW-1:0]].valid = 1'b1;
                    w_tree[1][w_rslot[SW-1:0]].leaf  = w_rnd;
                    w_tree[1][w_rslot[SW-1:0]].bnum  = r_block;
                    w_tree[1][w_rslot[SW-1:0]].data  =
                        r_write ? r_wdata : r_fetched;
                end
            end
            EVICT: begin
                for (int s = 0; s < K; s++) begin
                    w_lsh  = r_tree[r_node][s].leaf >> r_lvl;
                    w_slot = lowest(w_free);
                    if (r_tree[r_node][s].valid &&
                        (w_lsh[0] == w_pbit) && w_slot[SW]) begin
                        w_tree[w_child][w_slot[SW-1:0]] = r_tree[r_node][s];
                        w_tree[r_node][s].valid = 1'b0;
                        w_free[w_slot[SW-1:0]] = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bucket storage; reset wipes every tuple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 1; n <= NODES; n++) begin
                for (int s = 0; s < K; s++) begin
                    r_tree[n][s] <= '0;
                end
            end
        end else begin
            r_tree <= w_tree;
        end
    end

    // Access sequencer: lookup, path fetch, root insert, evictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pv        <= '0;
            for (int i = 0; i < N_BLOCKS; i++) begin
                r_pos[i] <= '0;
            end
            r_block     <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_leaf      <= '0;
            r_p         <= '0;
            r_node      <= L'(1);
            r_lvl       <= '0;
            r_pass      <= '0;
            r_fetched   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_block <= req_block;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_leaf    <= r_pv[r_block] ? r_pos[r_block] : w_rnd;
                    r_node    <= L'(1);
                    r_lvl     <= '0;
                    r_fetched <= '0;
                    r_state   <= FETCH;
                end
                FETCH: begin
                    if (w_hit[SW]) r_fetched <= w_hit_data;
                    r_node <= w_child;
                    r_lvl  <= r_lvl + 1'b1;
                    if (r_lvl == LW'(L - 1)) begin
                        r_state     <= PUT;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_hit[SW] ? w_hit_data : r_fetched;
                    end
                end
                PUT: begin
                    if (w_rslot[SW]) begin
                        r_pos[r_block] <= w_rnd;
                        r_pv[r_block]  <= 1'b1;
                    end else begin
                        r_pv[r_block]  <= 1'b0;
                        r_ovf          <= 1'b1;
                    end
                    r_node  <= L'(1);
                    r_lvl   <= '0;
                    r_pass  <= '0;
                    r_state <= (EVICTS == 0) ? IDLE : EVICT;
                end
                EVICT: begin
                    r_p <= w_p;
                    if (r_lvl == LW'(L - 2)) begin
                        r_node <= L'(1);
                        r_lvl  <= '0;
                        if (r_pass == PW'(EVICTS - 1)) begin
                            r_state <= IDLE;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                        end
                    end else begin
                        r_node <= w_child;
                        r_lvl  <= r_lvl + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ORAM_STATS_EN
    logic [31:0] r_acc;
    logic [15:0] r_ocnt;

    // Per-insert statistics: wrapping access count, saturating drop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_ocnt <= '0;
        end else if (r_state == PUT) begin
            r_acc <= r_acc + 32'd1;
            if (!w_rslot[SW] && (r_ocnt != 16'hFFFF)) begin
                r_ocnt <= r_ocnt + 16'd1;
            end
        end
    end

    assign access_cnt = r_acc;
    assign ovf_cnt    = r_ocnt;
`endif

endmodule

// File: tb/tb_oram_path_controller.sv
// Scoreboard bench: LFSR-accurate tree-ORAM reference model for one DUT,
// constant expectations for a small-bucket, no-eviction DUT.
module tb_oram_path_controller;

    localparam int BW    = 32;
    localparam int NB    = 8;
    localparam int L     = 3;
    localparam int LL    = 2;
    localparam int NODES = 7;
    localparam int KA    = 3;
    localparam int EA    = 2;
    localparam int KB    = 2;
    localparam int TW    = 1 + LL + L + BW;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic          a_valid = 1'b0, a_write = 1'b0;
    logic [L-1:0]  a_block = '0;
    logic [BW-1:0] a_wdata = '0;
    logic          a_ready, a_rsp_valid, a_ovf;
    logic [BW-1:0] a_rdata;
    logic          b_valid = 1'b0, b_write = 1'b0;
    logic [L-1:0]  b_block = '0;
    logic [BW-1:0] b_wdata = '0;
    logic          b_ready, b_rsp_valid, b_ovf;
    logic [BW-1:0] b_rdata;
`ifdef ORAM_STATS_EN
    logic [31:0] a_acc, b_acc;
    logic [15:0] a_ocnt, b_ocnt;
`endif

    oram_path_controller #(
        .BLOCK_BITS(BW), .N_BLOCKS(NB), .K(KA), .EVICTS(EA), .LFSR_SEED(SEED)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_block(a_block), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
`ifdef ORAM_STATS_EN
        .access_cnt(a_acc), .ovf_cnt(a_ocnt),
`endif
        .ovf(a_ovf)
    );

    oram_path_controller #(
        .BLOCK_BITS(BW), .N_BLOCKS(NB), .K(KB), .EVICTS(0), .LFSR_SEED(SEED)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_block(b_block), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
`ifdef ORAM_STATS_EN
        .access_cnt(b_acc), .ovf_cnt(b_ocnt),
`endif
        .ovf(b_ovf)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_t = 0;
    logic [15:0] m_lfsr = SEED;

    typedef struct packed {
        logic          v;
        logic [LL-1:0] leaf;
        logic [L-1:0]  b;
        logic [BW-1:0] d;
    } mt_t;

    mt_t           mt [1:NODES][KA];
    logic          mpv [NB];
    logic [LL-1:0] mpos [NB];
    logic          m_ovf = 1'b0;

    logic [BW-1:0] qa_d[$], qb_d[$];
    int            qa_c[$], qb_c[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lahead(input logic [15:0] v, input int n);
        logic [15:0] x = v;
        for (int i = 0; i < n; i++) x = lstep(x);
        return x;
    endfunction

    task automatic clear_model();
        for (int n = 1; n <= NODES; n++)
            for (int s = 0; s < KA; s++) mt[n][s] = '0;
        for (int i = 0; i < NB; i++) begin
            mpv[i] = 1'b0;
            mpos[i] = '0;
        end
        m_ovf = 1'b0;
    endtask

    // Cycle counter and LFSR value seen during the current cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        m_lfsr = rst_n ? lstep(m_lfsr) : SEED;
    end

    // Whole access for the modelled DUT, evaluated at the accept cycle.
    task automatic model_a(input logic w, input logic [L-1:0] b,
                           input logic [BW-1:0] d);
        logic [15:0]   base, tmp;
        logic [LL-1:0] leaf, nl, p;
        logic [BW-1:0] f;
        int node, c;
        bit placed;
        base = m_lfsr;
        f = '0;
        tmp = lahead(base, 1);
        leaf = mpv[b] ? mpos[b] : tmp[LL-1:0];
        node = 1;
        for (int dl = 0; dl < L; dl++) begin
            for (int s = 0; s < KA; s++)
                if (mt[node][s].v && mt[node][s].b == b) begin
                    f = mt[node][s].d;
                    mt[node][s].v = 1'b0;
                end
            if (dl < L - 1) node = 2 * node + int'(leaf[dl]);
        end
        qa_d.push_back(f);
        qa_c.push_back(cyc + L + 2);
        tmp = lahead(base, L + 2);
        nl = tmp[LL-1:0];
        placed = 0;
        for (int s = 0; s < KA; s++)
            if (!placed && !mt[1][s].v) begin
                mt[1][s] = '{v: 1'b1, leaf: nl, b: b, d: (w ? d : f)};
                placed = 1;
            end
        if (placed) begin
            mpv[b] = 1'b1;
            mpos[b] = nl;
        end else begin
            mpv[b] = 1'b0;
            m_ovf = 1'b1;
        end
        for (int j = 0; j < EA; j++) begin
            tmp = lahead(base, L + 3 + j * (L - 1));
            p = tmp[LL-1:0];
            node = 1;
            for (int dl = 0; dl < L - 1; dl++) begin
                c = 2 * node + int'(p[dl]);
                for (int s = 0; s < KA; s++)
                    if (mt[node][s].v && mt[node][s].leaf[dl] == p[dl])
                        for (int t = 0; t < KA; t++)
                            if (!mt[c][t].v) begin
                                mt[c][t] = mt[node][s];
                                mt[node][s].v = 1'b0;
                                break;
                            end
                node = c;
            end
        end
    endtask

    task automatic access(input int u, input logic w, input logic [L-1:0] b,
                          input logic [BW-1:0] d, input logic [BW-1:0] eb,
                          input bit wait_done);
        int g, lim;
        g = 0;
        @(negedge clk);
        while (!(u == 0 ? a_ready : b_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!(u == 0 ? a_ready : b_ready)) begin
            total++;
            bad++;
            $display("FAIL ready_timeout act=0 exp=1");
            return;
        end
        last_t = cyc;
        if (u == 0) begin
            a_valid = 1'b1; a_write = w; a_block = b; a_wdata = d;
            model_a(w, b, d);
        end else begin
            b_valid = 1'b1; b_write = w; b_block = b; b_wdata = d;
            qb_d.push_back(eb);
            qb_c.push_back(cyc + L + 2);
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (!wait_done) return;
        lim = last_t + L + 3 + ((u == 0) ? EA * (L - 1) : 0);
        g = 0;
        while (!(u == 0 ? a_ready : b_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(u == 0 ? "a_ready_cycle" : "b_ready_cycle", 64'(cyc), 64'(lim));
    endtask

    task automatic cmp_tree();
        logic [TW-1:0] av, ev;
        for (int n = 1; n <= NODES; n++)
            for (int s = 0; s < KA; s++) begin
                av = dut_a.r_tree[n][s];
                ev = mt[n][s];
                if (!av[TW-1]) av = '0;
                if (!ev[TW-1]) ev = '0;
                chk($sformatf("tree[%0d][%0d]", n, s), 64'(av), 64'(ev));
            end
    endtask

    // Response monitors: pop expected value and cycle on every pulse.
    always @(negedge clk) begin
        if (rst_n && a_rsp_valid) begin
            if (qa_d.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_rsp_unexpected act=%0h exp=none", a_rdata);
            end else begin
                chk("a_rdata", 64'(a_rdata), 64'(qa_d.pop_front()));
                chk("a_rsp_cycle", 64'(cyc), 64'(qa_c.pop_front()));
            end
        end
        if (rst_n && b_rsp_valid) begin
            if (qb_d.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_rsp_unexpected act=%0h exp=none", b_rdata);
            end else begin
                chk("b_rdata", 64'(b_rdata), 64'(qb_d.pop_front()));
                chk("b_rsp_cycle", 64'(cyc), 64'(qb_c.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_a_ready", 64'(a_ready), 64'(1));
        chk("rst_a_rsp_valid", 64'(a_rsp_valid), 64'(0));
        chk("rst_a_ovf", 64'(a_ovf), 64'(0));
        chk("rst_a_rdata", 64'(a_rdata), 64'(0));
        chk("rst_b_ready", 64'(b_ready), 64'(1));

        access(0, 1'b0, 3'd2, '0, '0, 1);
        chk("a_ovf_read2", 64'(a_ovf), 64'(0));
        access(0, 1'b1, 3'd1, 32'hDEADBEEF, '0, 1);
        access(0, 1'b0, 3'd1, '0, '0, 1);
        cmp_tree();

        access(1, 1'b1, 3'd0, 32'h1111_0000, 32'h0, 1);
        access(1, 1'b1, 3'd1, 32'h2222_0001, 32'h0, 1);
        chk("b_ovf_two", 64'(b_ovf), 64'(0));
        access(1, 1'b1, 3'd2, 32'h3333_0002, 32'h0, 1);
        chk("b_ovf_three", 64'(b_ovf), 64'(1));
        access(1, 1'b0, 3'd2, '0, 32'h0, 1);
        access(1, 1'b0, 3'd0, '0, 32'h1111_0000, 1);
        access(1, 1'b0, 3'd1, '0, 32'h2222_0001, 1);
        chk("b_ovf_sticky", 64'(b_ovf), 64'(1));

        for (int i = 0; i < 500; i++) begin
            access(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, NB - 1)),
                   $urandom, '0, 1);
            cmp_tree();
            chk("a_ovf", 64'(a_ovf), 64'(m_ovf));
        end

        access(0, 1'b1, 3'd5, 32'hCAFE_F00D, '0, 0);
        while (cyc < last_t + L + 3) @(negedge clk);
        chk("a_busy_in_evict", 64'(a_ready), 64'(0));
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_a_ready", 64'(a_ready), 64'(1));
        chk("rst2_a_ovf", 64'(a_ovf), 64'(0));
        chk("rst2_a_rdata", 64'(a_rdata), 64'(0));
        repeat (12) @(negedge clk);
        cmp_tree();
        for (int i = 0; i < NB; i++) access(0, 1'b0, 3'(i), '0, '0, 1);
        cmp_tree();

        repeat (4) @(negedge clk);
        chk("qa_drained", 64'(qa_d.size()), 64'(0));
        chk("qb_drained", 64'(qb_d.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
